// File: rtl/tri_3_input_nand_checker_pkg.sv
// Shared types, constants and the expected-response function for the
// triple 3-input NAND exhaustive checker.
package tri_gate_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int NUM_GATES   = 3;
  localparam int NUM_VECTORS = 8;
  localparam int MIN_SETTLE  = 3;

  // The gate under test answers ~&v; the idle gates see 000 and must answer 1.
  function automatic logic [2:0] expected_y(input logic [1:0] g, input logic [2:0] v);
    logic [2:0] e;
    e = '1;
    for (int i = 0; i < NUM_GATES; i++) begin
      if (g == i[1:0]) e[i] = ~&v;
    end
    return e;
  endfunction

endpackage

// File: rtl/tri_3_input_nand_checker_bit_synchronizer.sv
// Multi-bit 2-flop synchronizer for the asynchronous Y returns from the board.
module bit_synchronizer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back capture stages; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tri_3_input_nand_checker.sv
// Exhaustive tester for a triple 3-input NAND part: walks 8 vectors over each
// of the 3 gates, checks all returned Y bits every sample, and reports an
// error count plus the first failing sample.
//
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   DRIVE  | put the current vector on the gate under test, load settle timer
//   SETTLE | wait for the part and the synchronizer to settle
//   SAMPLE | compare synchronized Y with expectation, advance vector/gate
//   DONE   | results valid and held, outputs parked at 0, start reruns
module tri_3_input_nand_checker
  import tri_gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [2:0] a_out,
  output logic [2:0] b_out,
  output logic [2:0] c_out,
  input  logic [2:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [1:0] first_fail_gate,
  output logic [2:0] first_fail_vec,
  output logic [2:0] first_fail_y
);

  // Below MIN_SETTLE the synchronizer alone would eat the whole window.
  localparam int S_EFF = (SETTLE_CYCLES < MIN_SETTLE) ? MIN_SETTLE : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(S_EFF);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(S_EFF - 1);
  localparam logic [1:0] LAST_GATE = 2'(NUM_GATES - 1);
  localparam logic [2:0] LAST_VEC  = 3'(NUM_VECTORS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       gate_q;
  logic [2:0]       vec_q;
  logic [2:0]       a_q, b_q, c_q;
  logic             busy_q, done_q, pass_q;
  logic [4:0]       err_q;
  logic [1:0]       ff_gate_q;
  logic [2:0]       ff_vec_q;
  logic [2:0]       ff_y_q;

  logic [2:0] y_sync;
  logic [2:0] gate_mask;
  logic [2:0] exp_y;
  logic       mismatch;

  bit_synchronizer #(
    .WIDTH(3)
  ) u_y_sync (
    .clk  (clk),
    .rst_n(reset_n),
    .d_i  (y_in),
    .q_o  (y_sync)
  );

  // One-hot select of the gate under test, and the per-sample verdict.
  always_comb begin
    gate_mask = 3'b001 << gate_q;
    exp_y     = expected_y(gate_q, vec_q);
    mismatch  = (y_sync != exp_y);
  end

  // Sequencer with all status outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gate_q    <= '0;
      vec_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ff_gate_q <= '0;
      ff_vec_q  <= '0;
      ff_y_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            gate_q    <= '0;
            vec_q     <= '0;
            err_q     <= '0;
            ff_gate_q <= '0;
            ff_vec_q  <= '0;
            ff_y_q    <= '0;
            state_q   <= DRIVE;
          end
        end

        DRIVE: begin
          a_q     <= vec_q[2] ? gate_mask : 3'b000;
          b_q     <= vec_q[1] ? gate_mask : 3'b000;
          c_q     <= vec_q[0] ? gate_mask : 3'b000;
          busy_q  <= 1'b1;
          cnt_q   <= CNT_LOAD;
          state_q <= SETTLE;
        end

        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        SAMPLE: begin
          if (mismatch) begin
            err_q <= err_q + 1'b1;
            // Only the first mismatch of a run is recorded.
            if (err_q == '0) begin
              ff_gate_q <= gate_q;
              ff_vec_q  <= vec_q;
              ff_y_q    <= y_sync;
            end
          end
          if (gate_q == LAST_GATE && vec_q == LAST_VEC) begin
            state_q <= DONE;
          end else begin
            if (vec_q == LAST_VEC) gate_q <= gate_q + 1'b1;
            vec_q   <= vec_q + 1'b1;
            state_q <= DRIVE;
          end
        end

        DONE: begin
          a_q    <= '0;
          b_q    <= '0;
          c_q    <= '0;
          busy_q <= 1'b0;
          if (start) begin
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            gate_q    <= '0;
            vec_q     <= '0;
            err_q     <= '0;
            ff_gate_q <= '0;
            ff_vec_q  <= '0;
            ff_y_q    <= '0;
            state_q   <= DRIVE;
          end else begin
            done_q <= 1'b1;
            pass_q <= (err_q == '0);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign c_out           = c_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_gate = ff_gate_q;
  assign first_fail_vec  = ff_vec_q;
  assign first_fail_y    = ff_y_q;

endmodule

// File: tb/tb_tri_3_input_nand_checker.sv
// Directed bench: a behavioural 74LS10 with selectable faults feeds the
// checker; one instance runs at the default settle time, one with a settle
// parameter below the minimum.
module tb_tri_3_input_nand_checker;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic start3 = 1'b0;
  int   mode = 0;  // 0 good part, 1 gate-3 Y stuck high, 2 gate-2 is an AND

  logic [2:0] a_out, b_out, c_out, y_in;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [1:0] first_fail_gate;
  logic [2:0] first_fail_vec, first_fail_y;

  logic [2:0] a3, b3, c3, y3;
  logic       busy3, done3, pass3;
  logic [4:0] err3;
  logic [1:0] ffg3;
  logic [2:0] ffv3, ffy3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Board-side part model, zero delay.
  always_comb begin
    y_in = ~(a_out & b_out & c_out);
    if (mode == 1) y_in[2] = 1'b1;
    if (mode == 2) y_in[1] = a_out[1] & b_out[1] & c_out[1];
    y3 = ~(a3 & b3 & c3);
  end

  tri_3_input_nand_checker dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_gate(first_fail_gate), .first_fail_vec(first_fail_vec),
    .first_fail_y(first_fail_y)
  );

  tri_3_input_nand_checker #(.SETTLE_CYCLES(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3),
    .a_out(a3), .b_out(b3), .c_out(c3), .y_in(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_gate(ffg3), .first_fail_vec(ffv3), .first_fail_y(ffy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for edge k, then count edges after k until done rises.
  task automatic run_main(input int pulse_at, output int cyc, output int bcyc,
                          output logic [2:0] c6, output logic [2:0] c7);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0; bcyc = 0; c6 = 3'bxxx; c7 = 3'bxxx;
    while (cyc < 400) begin
      start = (cyc == pulse_at);
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (cyc == 6) c6 = c_out;
      if (cyc == 7) c7 = c_out;
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc, bcyc;
    logic [2:0] c6, c7;

    repeat (3) @(negedge clk);
    chk("rst_a_out", a_out, 3'b000);
    chk("rst_b_out", b_out, 3'b000);
    chk("rst_c_out", c_out, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err", err_count, 5'd0);
    chk("rst_ffg", first_fail_gate, 2'd0);
    chk("rst_ffv", first_fail_vec, 3'd0);
    chk("rst_ffy", first_fail_y, 3'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Good part: 24 vectors of 6 cycles each.
    mode = 0;
    run_main(-1, cyc, bcyc, c6, c7);
    chk("good_len", cyc, 145);
    chk("good_busy_cycles", bcyc, 144);
    chk("good_c_out_v0", c6, 3'b000);
    chk("good_c_out_v1", c7, 3'b001);
    chk("good_pass", pass, 1'b1);
    chk("good_err", err_count, 5'd0);
    chk("good_ffg", first_fail_gate, 2'd0);
    chk("good_a_parked", a_out, 3'b000);
    chk("good_busy_low", busy, 1'b0);

    // Gate 3 Y stuck at 1: only g=2, v=7 fails.
    mode = 1;
    run_main(-1, cyc, bcyc, c6, c7);
    chk("stuck_len", cyc, 145);
    chk("stuck_err", err_count, 5'd1);
    chk("stuck_ffg", first_fail_gate, 2'd2);
    chk("stuck_ffv", first_fail_vec, 3'd7);
    chk("stuck_ffy", first_fail_y, 3'b111);
    chk("stuck_pass", pass, 1'b0);
    chk("stuck_done", done, 1'b1);

    // Gate 2 as AND: idle 000 gives 0 instead of 1, so every sample fails.
    mode = 2;
    run_main(-1, cyc, bcyc, c6, c7);
    chk("and_err", err_count, 5'd24);
    chk("and_ffg", first_fail_gate, 2'd0);
    chk("and_ffv", first_fail_vec, 3'd0);
    chk("and_ffy", first_fail_y, 3'b101);
    chk("and_pass", pass, 1'b0);

    // Restart from DONE clears counts; a start pulse while busy is ignored.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_err_clr", err_count, 5'd0);
    chk("restart_done_clr", done, 1'b0);
    cyc = 0; bcyc = 0;
    while (cyc < 400) begin
      start = (cyc == 20);
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (done) break;
    end
    start = 1'b0;
    chk("busy_start_len", cyc, 145);
    chk("busy_start_pass", pass, 1'b1);
    repeat (5) @(negedge clk);
    chk("done_held", done, 1'b1);
    chk("no_rerun", busy, 1'b0);

    // Asynchronous reset at cycle 50 of a failing run.
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_busy_pre", busy, 1'b1);
    chk("mid_err_pre", err_count, 5'd8);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_busy_rst", busy, 1'b0);
    chk("mid_err_rst", err_count, 5'd0);
    chk("mid_ffy_rst", first_fail_y, 3'd0);
    chk("mid_done_rst", done, 1'b0);
    chk("mid_abc_rst", {a_out, b_out, c_out}, 9'd0);
    @(negedge clk) reset_n = 1'b1;
    mode = 0;
    run_main(-1, cyc, bcyc, c6, c7);
    chk("post_rst_len", cyc, 145);
    chk("post_rst_pass", pass, 1'b1);

    // SETTLE_CYCLES=1 clamps to 3: 24 vectors of 5 cycles.
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    cyc = 0; bcyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy3) bcyc++;
      if (done3) break;
    end
    chk("clamp_len", cyc, 121);
    chk("clamp_busy_cycles", bcyc, 120);
    chk("clamp_pass", pass3, 1'b1);
    chk("clamp_err", err3, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
